fp32_multiplier: RTL and testbench
==================================

FP32_MULTIPLIER -- requirements
Module: fp32_multiplier

Interface
REQ-001 Parameters: none; the operand format is fixed at IEEE 754 binary32.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 rs1  input  32  operand A, IEEE 754 single precision.
REQ-005 rs2  input  32  operand B, IEEE 754 single precision.
REQ-006 start  input  1  request pulse; rs1/rs2 are captured on the same edge when the unit is idle.
REQ-007 result  output  32  product, IEEE 754 single precision, registered.
REQ-008 valid  output  1  one-cycle pulse marking a new result.
REQ-009 busy  output  1  high while an operation is in flight.

Function
REQ-010 FSM states: IDLE, MUL, NORM, ROUND; reset state IDLE.
REQ-011 IDLE with start=1 at edge N: latch sign = rs1[31]^rs2[31], exponents, mantissas and special-case flags; go to MUL; busy=1 from edge N.
REQ-012 MUL at edge N+1: form the 48-bit product of the two 24-bit significands (hidden 1 restored); exponent sum = eA+eB-127 (10-bit signed); go to NORM.
REQ-013 NORM at edge N+2: if product bit47=1, shift right 1 and exponent+1; keep guard and round bits plus a sticky OR of all lower bits; go to ROUND.
REQ-014 ROUND at edge N+3: round to nearest, ties to even; on mantissa carry-out, exponent+1 and mantissa=0; write result; valid=1 for exactly one cycle; busy=0; go to IDLE.
REQ-015 Latency: valid is high in the cycle following edge N+3 (4 clocks after start is sampled); maximum throughput is one operation per 4 cycles.
REQ-016 start is ignored while busy=1; rs1/rs2 changes after capture do not affect the operation in flight.
REQ-017 start=1 in the same cycle valid=1 (state is IDLE) is accepted, giving back-to-back operations.
REQ-018 result holds its value until the next ROUND write; valid is 0 in every other cycle.
REQ-019 Denormal inputs (exp=0) are treated as signed zero; denormal or underflowing results (final exp<=0) flush to signed zero.
REQ-020 Any NaN input, or inf*0, gives canonical quiet NaN 0x7FC00000.
REQ-021 inf times finite nonzero, or inf*inf, gives inf with the XOR sign.
REQ-022 zero times finite gives zero with the XOR sign.
REQ-023 Overflow (final exp>=255 after rounding) gives inf with the XOR sign.
REQ-024 Special cases still take the full 4-cycle latency; the result is forced in ROUND.

Reset
REQ-025 On rst=1 at a clock edge: result=0x00000000, valid=0, busy=0, state=IDLE.
REQ-026 rst has priority over start; reset mid-operation aborts the operation and no valid pulse is produced for it.
REQ-027 The first start after rst is released is accepted normally.

Verification
REQ-028 rs1=0x3FC00000, rs2=0x40000000, start pulse -> busy for 4 cycles, then valid pulse with result=0x40400000.
REQ-029 Sign and rounding:
- 0xC0000000*0x3F000000 -> 0xBF800000.
- 0x3F800001*0x3F800001 -> 0x3F800002.
REQ-030 Specials:
- 0x7F800000*0x00000000 -> 0x7FC00000.
- 0x7F7FFFFF*0x40000000 -> 0x7F800000.
- 0x00000001*0x3F800000 -> 0x00000000.
- 0x80000000*0x3F800000 -> 0x80000000.
REQ-031 Second start pulsed 1 cycle after the first -> exactly one valid pulse, carrying the first operands' product; busy never deasserts early.
REQ-032 rst asserted 2 cycles after start -> no valid pulse, result=0, busy=0 the cycle after the reset edge.
REQ-033 start held high continuously with fixed operands -> valid pulses every 4 cycles with an identical result each time.

Source files
------------

// File: rtl/fp32_multiplier.sv
// IEEE 754 binary32 multiplier: four-state pipeline (IDLE/MUL/NORM/ROUND) with a
// one-cycle valid pulse, round-to-nearest-even, and flush-to-zero for denormals.
module fp32_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        start,
  output logic [31:0] result,
  output logic        valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_NORM,
    S_ROUND
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t             r_state;
  logic               r_sign;
  logic [7:0]         r_exp_a;
  logic [7:0]         r_exp_b;
  logic [22:0]        r_man_a;
  logic [22:0]        r_man_b;
  logic               r_nan;
  logic               r_inf;
  logic               r_zero;
  logic [47:0]        r_prod;
  logic signed [9:0]  r_exp;
  logic [23:0]        r_sig;
  logic               r_guard;
  logic               r_round;
  logic               r_sticky;

  // Operand classification, sampled only when an operation is accepted.
  logic [7:0]  w_exp_a;
  logic [7:0]  w_exp_b;
  logic [22:0] w_man_a;
  logic [22:0] w_man_b;
  logic        w_a_zero;
  logic        w_b_zero;
  logic        w_a_inf;
  logic        w_b_inf;
  logic        w_a_nan;
  logic        w_b_nan;

  assign w_exp_a  = rs1[30:23];
  assign w_exp_b  = rs2[30:23];
  assign w_man_a  = rs1[22:0];
  assign w_man_b  = rs2[22:0];
  // Denormals (exponent 0) are treated as signed zero.
  assign w_a_zero = (w_exp_a == 8'd0);
  assign w_b_zero = (w_exp_b == 8'd0);
  assign w_a_inf  = (w_exp_a == 8'hFF) && (w_man_a == 23'd0);
  assign w_b_inf  = (w_exp_b == 8'hFF) && (w_man_b == 23'd0);
  assign w_a_nan  = (w_exp_a == 8'hFF) && (w_man_a != 23'd0);
  assign w_b_nan  = (w_exp_b == 8'hFF) && (w_man_b != 23'd0);

  logic [23:0] w_sig_a;
  logic [23:0] w_sig_b;
  logic [9:0]  w_exp_sum;

  assign w_sig_a   = {1'b1, r_man_a};
  assign w_sig_b   = {1'b1, r_man_b};
  assign w_exp_sum = {2'b00, r_exp_a} + {2'b00, r_exp_b} - 10'd127;

  // Rounding and final packing, consumed in the ROUND state.
  logic              w_round_up;
  logic [24:0]       w_sig_rnd;
  logic signed [9:0] w_exp_rnd;
  logic [22:0]       w_man_out;
  logic [31:0]       w_result;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch is inferred; clocked state below uses '<=' only.
  always_comb begin
    w_round_up = r_guard & (r_round | r_sticky | r_sig[0]);
    w_sig_rnd  = {1'b0, r_sig} + {24'd0, w_round_up};
    w_exp_rnd  = r_exp;
    w_man_out  = w_sig_rnd[22:0];
    if (w_sig_rnd[24]) begin
      w_exp_rnd = r_exp + 10'sd1;
      w_man_out = 23'd0;
    end

    w_result = {r_sign, w_exp_rnd[7:0], w_man_out};
    if (r_nan) begin
      w_result = QNAN;
    end else if (r_inf) begin
      w_result = {r_sign, 8'hFF, 23'd0};
    end else if (r_zero) begin
      w_result = {r_sign, 31'd0};
    end else if (w_exp_rnd >= 10'sd255) begin
      w_result = {r_sign, 8'hFF, 23'd0};
    end else if (w_exp_rnd <= 10'sd0) begin
      w_result = {r_sign, 31'd0};
    end
  end

  // NOTE: only the control state and the outputs are reset; datapath registers
  // are always rewritten before they are read, so they need no reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      result  <= 32'd0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign  <= rs1[31] ^ rs2[31];
            r_exp_a <= w_exp_a;
            r_exp_b <= w_exp_b;
            r_man_a <= w_man_a;
            r_man_b <= w_man_b;
            r_nan   <= w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
            r_inf   <= w_a_inf | w_b_inf;
            r_zero  <= w_a_zero | w_b_zero;
            busy    <= 1'b1;
            r_state <= S_MUL;
          end
        end

        S_MUL: begin
          r_prod  <= 48'(w_sig_a) * 48'(w_sig_b);
          r_exp   <= $signed(w_exp_sum);
          r_state <= S_NORM;
        end

        S_NORM: begin
          // Product of two [1,2) significands lies in [1,4): at most one shift.
          if (r_prod[47]) begin
            r_sig    <= r_prod[47:24];
            r_guard  <= r_prod[23];
            r_round  <= r_prod[22];
            r_sticky <= |r_prod[21:0];
            r_exp    <= r_exp + 10'sd1;
          end else begin
            r_sig    <= r_prod[46:23];
            r_guard  <= r_prod[22];
            r_round  <= r_prod[21];
            r_sticky <= |r_prod[20:0];
          end
          r_state <= S_ROUND;
        end

        S_ROUND: begin
          result  <= w_result;
          valid   <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_multiplier.sv
// Scoreboard bench for fp32_multiplier: directed vectors push expected products,
// a negedge monitor pops and compares whenever valid is presented.
module tb_fp32_multiplier;

  logic        clk;
  logic        rst;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        start;
  logic [31:0] result;
  logic        valid;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  fp32_multiplier dut (
    .clk    (clk),
    .rst    (rst),
    .rs1    (rs1),
    .rs2    (rs2),
    .start  (start),
    .result (result),
    .valid  (valid),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_valid: got result %h, expected no valid pulse", result);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string       n = name_q.pop_front();
        check(n, result, e);
        check({n, "_busy_low"}, {31'd0, busy}, 32'd0);
      end
    end
  end

  // One operation with a one-cycle start; operands are scrambled right after
  // capture, and the valid pulse must land exactly 4 cycles after the start edge.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e);
    int cyc;
    @(negedge clk);
    rs1 = a;
    rs2 = b;
    start = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(negedge clk);
    start = 1'b0;
    rs1 = 32'h7FC0_1234;
    rs2 = 32'hFFFF_FFFF;
    cyc = 1;
    check({name, "_busy"}, {31'd0, busy}, 32'd1);
    while (!valid && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, cyc, 32'd4);
  endtask

  initial begin
    int nv;
    rst = 1'b1;
    start = 1'b0;
    rs1 = 32'd0;
    rs2 = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_result", result, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    run_op("basic_1p5x2", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000);
    run_op("sign_neg",    32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000);
    run_op("round_small", 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
    run_op("tie_odd_up",  32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002);
    run_op("tie_even_dn", 32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004);
    run_op("round_carry", 32'h3FFF_FFFF, 32'h3F80_0001, 32'h4000_0000);
    run_op("inf_x_zero",  32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
    run_op("zero_x_ninf", 32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0000);
    run_op("nan_in",      32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000);
    run_op("inf_x_neg",   32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000);
    run_op("overflow",    32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000);
    run_op("denorm_in",   32'h0000_0001, 32'h3F80_0000, 32'h0000_0000);
    run_op("neg_zero",    32'h8000_0000, 32'h3F80_0000, 32'h8000_0000);
    run_op("underflow",   32'h8080_0000, 32'h0080_0000, 32'h8000_0000);

    // Second start one cycle after the first must be ignored.
    @(negedge clk);
    rs1 = 32'h3FC0_0000;
    rs2 = 32'h4000_0000;
    start = 1'b1;
    exp_q.push_back(32'h4040_0000);
    name_q.push_back("ignored_start");
    @(negedge clk);
    rs1 = 32'h4000_0000;
    rs2 = 32'h4000_0000;
    @(negedge clk);
    start = 1'b0;
    nv = 0;
    for (int cyc = 2; cyc <= 10; cyc++) begin
      if (cyc > 2) @(negedge clk);
      if (cyc < 4) check("ignored_start_busy", {31'd0, busy}, 32'd1);
      if (valid) nv++;
    end
    check("ignored_start_pulses", nv, 32'd1);

    // Reset two cycles after start aborts the operation.
    @(negedge clk);
    rs1 = 32'h4000_0000;
    rs2 = 32'h4000_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_result", result, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, valid}, 32'd0);
    repeat (6) @(negedge clk);

    run_op("after_reset", 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000);

    // start held high: accepted every 4 cycles, valid at offsets 3, 7, 11.
    @(negedge clk);
    rs1 = 32'hC040_0000;
    rs2 = 32'h4040_0000;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'hC110_0000);
      name_q.push_back("held_start");
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("held_start_valid_timing", {31'd0, valid}, {31'd0, (i % 4) == 3});
    end
    start = 1'b0;

    repeat (8) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
